key_repeat_ctrl: RTL and testbench

Auto-repeat controller for the RPN calculator keypad. It consumes the one-cycle tick from `enable_gen` (`enable_out`) and turns a held key into a stream of one-cycle `key_event` pulses. Each pulse is one key entry for the RPN input stage. After a configurable number of slow repeats it drives `enable_gen`'s `mode` input high (turbo), so the repeat rate speeds up. It sits between the keypad debouncer and the RPN entry logic, and is the only driver of `enable_gen.mode`.

---
 rtl/kr_pkg.sv | 6 +
 rtl/key_repeat_ctrl.sv | 73 +++++++
 tb/tb_key_repeat_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/kr_pkg.sv
// kr_pkg: state type and default timing constants for key_repeat_ctrl
package kr_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, TURBO} kr_state_t;
    localparam int KR_DELAY_TICKS = 3;
    localparam int KR_TURBO_AFTER = 4;
endpackage

// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl: turns a held key into press/repeat event pulses and engages turbo after slow repeats
module key_repeat_ctrl
    import kr_pkg::*;
#(
    parameter int DELAY_TICKS = KR_DELAY_TICKS,
    parameter int TURBO_AFTER = KR_TURBO_AFTER,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_held,
    input  logic tick,
    output logic key_event,
    output logic turbo_mode
);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] TURBO_LAST = CNT_W'(TURBO_AFTER);
    kr_state_t state, state_nxt;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt, tick_inc, rep_cnt, rep_cnt_nxt, rep_inc;
    logic delay_done, event_nxt, turbo_nxt;
    assign tick_inc = tick_cnt == '1 ? tick_cnt : tick_cnt + 1'b1;
    assign rep_inc = rep_cnt == '1 ? rep_cnt : rep_cnt + 1'b1;
    assign delay_done = tick && tick_cnt == DELAY_LAST;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tick_cnt <= '0;
            rep_cnt <= '0;
            key_event <= 1'b0;
            turbo_mode <= 1'b0;
        end else begin
            state <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            rep_cnt <= rep_cnt_nxt;
            key_event <= event_nxt;
            turbo_mode <= turbo_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        tick_cnt_nxt = tick_cnt;
        rep_cnt_nxt = rep_cnt;
        if (!key_held) begin
            state_nxt = IDLE;
            tick_cnt_nxt = '0;
            rep_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = DELAY;
                    tick_cnt_nxt = '0;
                end
                DELAY: begin
                    tick_cnt_nxt = tick ? tick_inc : tick_cnt;
                    if (delay_done) begin
                        state_nxt = TURBO_AFTER == 1 ? TURBO : REPEAT;
                        rep_cnt_nxt = CNT_W'(1);
                    end
                end
                REPEAT: if (tick) begin
                    rep_cnt_nxt = rep_inc;
                    state_nxt = rep_inc == TURBO_LAST ? TURBO : REPEAT;
                end
                default: ;
            endcase
        end
    end
    // Release wins over any tick in the same cycle
    always_comb begin
        event_nxt = key_held && (state == IDLE || (state == DELAY ? delay_done : tick));
        turbo_nxt = state_nxt == TURBO;
    end
endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb_key_repeat_ctrl: directed and random stimulus checked against an event-counting reference model
module tb_key_repeat_ctrl;
    localparam int DT = 3;
    localparam int TA = 4;
    logic clk = 1'b0;
    logic reset;
    logic key_held;
    logic tick;
    logic key_event;
    logic turbo_mode;
    int checks = 0;
    int errors = 0;
    int n_events = 0;
    bit m_active;
    int m_ticks;
    int m_reps;
    bit exp_ev;
    bit exp_turbo;
    key_repeat_ctrl #(.DELAY_TICKS(DT), .TURBO_AFTER(TA), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .key_held(key_held),
        .tick(tick),
        .key_event(key_event),
        .turbo_mode(turbo_mode)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_clear();
        m_active = 0;
        m_ticks = 0;
        m_reps = 0;
        exp_ev = 0;
        exp_turbo = 0;
    endtask
    // Model: events fire at press and at every tick from the DT-th tick after press on
    task automatic step(input logic k, input logic t);
        @(negedge clk);
        key_held = k;
        tick = t;
        @(posedge clk);
        if (!reset || !k) model_clear();
        else if (!m_active) begin
            model_clear();
            m_active = 1;
            exp_ev = 1;
        end else begin
            exp_ev = 0;
            if (t) begin
                m_ticks++;
                if (m_ticks >= DT) begin
                    exp_ev = 1;
                    m_reps++;
                end
            end
            exp_turbo = m_reps >= TA;
        end
        #1;
        check("key_event", int'(key_event), int'(exp_ev));
        check("turbo_mode", int'(turbo_mode), int'(exp_turbo));
        n_events += int'(key_event);
    endtask
    task automatic hold(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, i % 5 == 4);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic k;
        reset = 1'b0;
        key_held = 1'b1;
        tick = 1'b0;
        model_clear();
        #1;
        check("reset_event", int'(key_event), 0);
        check("reset_turbo", int'(turbo_mode), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'(i % 2));
        reset = 1'b1;
        n_events = 0;
        step(1'b1, 1'b0);
        check("reset_release_press", n_events, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_events = 0;
        hold(60);
        check("full_seq_events", n_events, 11);
        check("full_seq_turbo", int'(turbo_mode), 1);
        step(1'b0, 1'b0);
        n_events = 0;
        hold(10);
        for (int i = 0; i < 20; i++) step(1'b0, i % 5 == 4);
        check("delay_release_events", n_events, 1);
        hold(45);
        check("pre_release_turbo", int'(turbo_mode), 1);
        n_events = 0;
        step(1'b0, 1'b1);
        check("turbo_release_events", n_events, 0);
        step(1'b1, 1'b0);
        check("repress_after_turbo", n_events, 1);
        hold(40);
        check("pre_reset_turbo", int'(turbo_mode), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_turbo", int'(turbo_mode), 0);
        check("async_event", int'(key_event), 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        reset = 1'b1;
        n_events = 0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("min_press_events", n_events, 1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_events = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, i % 5 == 4);
        check("repress_delay_events", n_events, 1);
        step(1'b1, 1'b1);
        check("repress_first_repeat", n_events, 2);
        k = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) k = ~k;
            step(k, $urandom_range(0, 2) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
